// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with valid/ready output.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          rx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Synchronizer and edge detector; armed_q blocks a false edge when the
  // line is already low as the reset-valued flops drain after reset.
  logic       sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] fill_q;
  logic       fall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && sync2_q) armed_q <= 1'b1;
    end
  end

  assign fall_c = armed_q & prev_q & ~sync2_q;

  // Frame FSM state and datapath registers
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            busy_q, ferr_q, ferr_d;
  logic            push_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push_c  = 1'b0;
    if (state_q != IDLE) cnt_d = cnt_q - CW'(1);
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LOAD;
          bit_d = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LOAD;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          push_c  = sync2_q;
          ferr_d  = ~sync2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head pops together
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          valid_q, ovf_q, ovf_d;
  logic          full_c, pop_c, wr_c;

  always_comb begin
    full_c  = (count_q == DEPTH_CNT);
    pop_c   = valid_q & rx_ready_i;
    wr_c    = push_c & (~full_c | pop_c);
    ovf_d   = push_c & full_c & ~pop_c;
    rd_d    = pop_c ? rd_q + AW'(1) : rd_q;
    wr_d    = wr_c ? wr_q + AW'(1) : wr_q;
    count_d = count_q;
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    head_d = (wr_c && (wr_q == rd_d)) ? shift_q : mem[rd_d];
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= (state_d != IDLE);
      ferr_q  <= ferr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= (count_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign rx_data_o    = head_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign rx_busy_o    = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: exact-timing single frame, table of frames, hand-written
// corner sequences and a randomized run against a byte-queue reference model.
module tb_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned H     = CPB / 2;
  // Cycles from driving the start bit to rx_valid_o rising: 2 sync + H + 9 bits + 1
  localparam int unsigned VALID_LAT = 2 + H + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst, rx_i, rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overflow_o, rx_busy_o;
  logic [3:0] fifo_count_o;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o),
    .rx_busy_o    (rx_busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] popped[$];
  logic [7:0] expq[$];

  // Observe flag pulses and accepted bytes at the edge (pre-update values)
  always @(posedge clk) begin
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (overflow_o) ovf_cnt <= ovf_cnt + 1;
    if (rx_valid_o && rx_ready_i) popped.push_back(rx_data_o);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = stop;
    tick(CPB);
  endtask

  task automatic drain();
    rx_ready_i = 1'b1;
    tick(DEPTH + 4);
    rx_ready_i = 1'b0;
    tick(1);
  endtask

  task automatic check_popped(input string name);
    check({name, "_len"}, 32'(popped.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < popped.size(); i++)
      check(name, 32'(popped[i]), 32'(expq[i]));
  endtask

  vec_t vecs[6];
  int   f0, o0, nexp_ferr;
  logic done;
  logic [7:0] rb;
  logic rstop;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'hC3, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1};

    rst = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check("rst_valid", 32'(rx_valid_o), 0);
    check("rst_count", 32'(fifo_count_o), 0);
    check("rst_ferr", 32'(frame_err_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_busy", 32'(rx_busy_o), 0);
    check("rst_data", 32'(rx_data_o), 0);

    // Single byte with exact timing
    fork
      send_frame(8'h55, 1'b1);
      begin
        tick(2);
        check("busy_before_t0", 32'(rx_busy_o), 0);
        tick(1);
        check("busy_rise", 32'(rx_busy_o), 1);
        tick(VALID_LAT - 4);
        check("valid_early", 32'(rx_valid_o), 0);
        tick(1);
        check("valid_rise", 32'(rx_valid_o), 1);
        check("single_data", 32'(rx_data_o), 32'h55);
        check("busy_fall", 32'(rx_busy_o), 0);
        check("single_count", 32'(fifo_count_o), 1);
      end
    join
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    check("pop_count", 32'(fifo_count_o), 0);
    check("pop_valid", 32'(rx_valid_o), 0);

    // Glitch rejection
    tick(CPB);
    f0 = ferr_cnt;
    rx_i = 1'b0;
    fork
      begin tick(4); rx_i = 1'b1; end
      begin
        tick(2 + H);
        check("glitch_busy_hold", 32'(rx_busy_o), 1);
        tick(1);
        check("glitch_idle", 32'(rx_busy_o), 0);
      end
    join
    tick(2 * CPB);
    check("glitch_count", 32'(fifo_count_o), 0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 0);

    // Framing error, long low line, recovery
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    tick(20 * CPB);
    check("ferr_once", 32'(ferr_cnt - f0), 1);
    check("ferr_count", 32'(fifo_count_o), 0);
    check("ferr_busy", 32'(rx_busy_o), 0);
    rx_i = 1'b1;
    tick(2 * CPB);
    popped.delete();
    send_frame(8'h3C, 1'b1);
    tick(CPB);
    check("recover_count", 32'(fifo_count_o), 1);
    drain();
    expq.delete();
    expq.push_back(8'h3C);
    check_popped("recover");

    // Table of frames
    foreach (vecs[v]) begin
      f0 = ferr_cnt;
      popped.delete();
      send_frame(vecs[v].data, vecs[v].stop);
      rx_i = 1'b1;
      tick(CPB);
      check("vec_count", 32'(fifo_count_o), 32'(vecs[v].exp_push));
      check("vec_ferr", 32'(ferr_cnt - f0), 32'(!vecs[v].exp_push));
      drain();
      expq.delete();
      if (vecs[v].exp_push) expq.push_back(vecs[v].data);
      check_popped("vec_data");
    end

    // Overflow on the 9th back-to-back byte
    o0 = ovf_cnt;
    popped.delete();
    expq.delete();
    for (int b = 0; b < 9; b++) begin
      send_frame(8'(b), 1'b1);
      if (b < 8) expq.push_back(8'(b));
    end
    tick(CPB);
    check("ovf_once", 32'(ovf_cnt - o0), 1);
    check("ovf_count", 32'(fifo_count_o), 8);
    drain();
    check_popped("ovf_drain");

    // Full FIFO with pop in the push cycle
    popped.delete();
    expq.delete();
    for (int b = 0; b < 8; b++) begin
      send_frame(8'h10 + 8'(b), 1'b1);
      expq.push_back(8'h10 + 8'(b));
    end
    expq.push_back(8'h18);
    tick(CPB);
    check("full_count", 32'(fifo_count_o), 8);
    o0 = ovf_cnt;
    fork
      send_frame(8'h18, 1'b1);
      begin
        tick(VALID_LAT - 1);
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
        check("fullpop_count", 32'(fifo_count_o), 8);
      end
    join
    tick(CPB);
    check("fullpop_ovf", 32'(ovf_cnt - o0), 0);
    drain();
    check_popped("fullpop_drain");

    // Reset mid-frame with two queued bytes
    send_frame(8'h21, 1'b1);
    send_frame(8'h42, 1'b1);
    tick(CPB);
    check("pre_rst_count", 32'(fifo_count_o), 2);
    f0 = ferr_cnt;
    popped.delete();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(70);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_count", 32'(fifo_count_o), 0);
        check("mid_rst_valid", 32'(rx_valid_o), 0);
        check("mid_rst_busy", 32'(rx_busy_o), 0);
        check("mid_rst_data", 32'(rx_data_o), 0);
        check("mid_rst_ferr", 32'(frame_err_o), 0);
        check("mid_rst_ovf", 32'(overflow_o), 0);
      end
    join
    tick(3 * CPB);
    check("trail_count", 32'(fifo_count_o), 0);
    check("trail_ferr", 32'(ferr_cnt - f0), 0);
    check("trail_busy", 32'(rx_busy_o), 0);
    send_frame(8'h7E, 1'b1);
    tick(CPB);
    drain();
    expq.delete();
    expq.push_back(8'h7E);
    check_popped("post_rst");

    // Randomized frames with random consumer back-pressure
    popped.delete();
    expq.delete();
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    nexp_ferr = 0;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          rb = 8'($urandom);
          rstop = ($urandom % 5) != 0;
          if (rstop) expq.push_back(rb);
          else nexp_ferr++;
          send_frame(rb, rstop);
          rx_i = 1'b1;
          tick(2 + int'($urandom % 20));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready_i = 1'($urandom % 2);
          tick(1);
        end
        rx_ready_i = 1'b0;
      end
    join
    tick(CPB);
    drain();
    check_popped("rand_data");
    check("rand_ferr", 32'(ferr_cnt - f0), 32'(nexp_ferr));
    check("rand_ovf", 32'(ovf_cnt - o0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable 8N1 UART receiver that decodes the serial stream driven on the core's `uart_tx_o` pin. It closes the loop on the console path: self-checking benches and the FPGA bring-up harness can recover transmitted characters as a byte stream instead of scraping store traffic. It sits outside the core and runs on the core clock domain. The asynchronous serial input is synchronized internally, and received bytes are buffered in a first-word-fall-through FIFO with a valid/ready output.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of two and ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_i`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data_o`  out  8  FIFO head byte; valid only while `rx_valid_o`=1.
- `rx_valid_o`  out  1  FIFO non-empty.
- `rx_ready_i`  in  1  consumer accepts the head byte when `rx_valid_o` & `rx_ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overflow_o`  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- `rx_busy_o`  out  1  FSM not in IDLE.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchronizer.** `rx_i` passes through a 2-flop synchronizer; both flops reset to 1. A `prev` register holds the last synchronized value and also resets to 1.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when synchronized = 0 and `prev` = 1 (a falling edge). A line held low never retriggers.
  - START: wait H = CLKS_PER_BIT/2 cycles (integer division), then sample. Sample = 1 is a false start: return to IDLE, no flags. Sample = 0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE. Sample = 1 pushes the byte. Sample = 0 discards the byte and pulses `frame_err_o`.
- **Counters.** The bit-period counter is $clog2(CLKS_PER_BIT) bits wide and reloads on every sample. The bit index is 3 bits.
- **FIFO write rules:**
  - Push when not full: the byte is written at the tail and count increments.
  - Push when full with no pop that cycle: byte dropped, `overflow_o` pulses, contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while non-empty: count unchanged.
- **FIFO read rules.**
  - Pop when `rx_valid_o` & `rx_ready_i`.
  - `rx_ready_i` while empty is ignored.
- **Pointers.** Read and write pointers wrap modulo FIFO_DEPTH.
- **Reset mid-frame.** The frame is aborted and the FSM returns to IDLE. The FIFO is emptied and pending flags are cleared. A low line at reset release causes no edge detection until the line has returned high.

## Timing
- **Reset values:** `rx_valid_o`=0, `fifo_count_o`=0, `frame_err_o`=0, `overflow_o`=0, `rx_busy_o`=0. `rx_data_o` is don't-care; implement it as 0.
- **Synchronizer delay.** A change on `rx_i` reaches the synchronized signal 2 rising edges later.
- **Frame sample points.** Let T0 be the cycle in which the edge is detected; `rx_busy_o` rises at T0+1.
  - Start bit sampled at T0+H.
  - Data bit i sampled at T0+H+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at T0+H+9·CLKS_PER_BIT.
- **Completion.** `rx_valid_o` / `fifo_count_o` update, or `frame_err_o` / `overflow_o` pulse, one cycle after the stop sample. `rx_busy_o` falls in that same cycle.
- **Pop timing.**
  - A pop updates `rx_data_o` and count on the next edge.
  - FWFT: the head byte is visible in the same cycle as `rx_valid_o`.
- **Back-to-back frames.** A new start edge is accepted the cycle after returning to IDLE. This tolerates a transmitter running up to about 4% fast.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and FIFO_DEPTH = 8.
- **Single byte.** Drive 0x55 8N1 → `rx_valid_o` rises exactly T0+8+144+1 with `rx_data_o`=0x55. Pop → count 0.
- **Glitch rejection.** Drive a 4-cycle low pulse on an idle line → no push, no `frame_err_o`, FSM back in IDLE by T0+9.
- **Framing error and recovery.**
  - Drive 0xA5 with stop = 0 → `frame_err_o` pulses once and count stays 0.
  - Hold the line low 20 bit-times → no further frames.
  - Release high, then send 0x3C → 0x3C received.
- **Overflow.**
  - With `rx_ready_i`=0, send bytes 0x00–0x08 back-to-back → count 8 and `overflow_o` pulses once, on the 9th byte.
  - Then drain → 0x00..0x07 in order.
- **Full with simultaneous pop.** With the FIFO full, assert `rx_ready_i` in the push cycle → count stays 8, no overflow, and the new byte appears last on drain.
- **Reset mid-frame.** Assert `rst` for 1 cycle during bit 3 of a frame, with 2 bytes already queued → count 0, all outputs at reset values. Trailing frame bits produce no byte; the next clean frame (0x7E) is received correctly.
